// File: rtl/div_scheduler.sv
// div_scheduler
// Shares one iterative restoring divider between two requesters. The divider
// produces one quotient bit per clock. Results return on a single registered
// response port, tagged with the ID of the requester that issued them.
//
// Handshake (both request ports and the response port): a transfer happens on
// a rising edge where valid && ready are both high. A source holds valid and
// its payload stable until that edge. Request readys are combinational from
// the valids and the FSM state. rsp_valid is registered and does not wait on
// rsp_ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req{0,1}_valid       requester has an operation
//   req{0,1}_a / _b      dividend / divisor
//   req{0,1}_ready       requester is accepted this cycle
//   rsp_valid/rsp_ready  response handshake
//   rsp_id               requester that issued the operation
//   rsp_q / rsp_r        quotient / remainder
//   rsp_dbz              divisor was zero (q = all ones, r = dividend)
//   dbg_state            FSM state (0 IDLE, 1 DIV, 2 DONE)
module div_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             dbz_q, dbz_d;

    // Arbitration and operand selection
    logic             any_valid;
    logic             gnt_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    always_comb begin
        any_valid = req0_valid | req1_valid;
        // With a single valid the grant goes to it; with both, the pointer decides.
        gnt_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        sel_a     = gnt_id ? req1_a : req0_a;
        sel_b     = gnt_id ? req1_b : req0_b;
    end

    // One restoring step: t = {r, q_msb}. When t >= b the difference is
    // below b, so its low WIDTH bits carry the complete remainder.
    logic [WIDTH:0]   step_t;
    logic             step_ge;
    logic [WIDTH-1:0] step_sub;

    always_comb begin
        step_t   = {r_q, q_q[WIDTH-1]};
        step_ge  = (step_t >= {1'b0, b_q});
        step_sub = step_t[WIDTH-1:0] - b_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            b_q     <= b_d;
            id_q    <= id_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        b_d     = b_q;
        id_d    = id_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    id_d = gnt_id;
                    b_d  = sel_b;
                    if (sel_b == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        r_d     = sel_a;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        q_d     = sel_a;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                q_d   = {q_q[WIDTH-2:0], step_ge};
                r_d   = step_ge ? step_sub : step_t[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    // The requester just served loses the next tie.
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        // Gated by rst_n so the readys hold their reset value while reset is low.
        req0_ready = rst_n && (state_q == IDLE) && any_valid && !gnt_id;
        req1_ready = rst_n && (state_q == IDLE) && any_valid &&  gnt_id;
        rsp_valid  = (state_q == DONE);
        rsp_id     = id_q;
        rsp_q      = q_q;
        rsp_r      = r_q;
        rsp_dbz    = dbz_q;
        dbg_state  = state_q;
    end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one iterative unsigned divider between two requesters. Each accepted request (dividend, divisor) is computed by a restoring shift/subtract datapath, one quotient bit per clock. The quotient and remainder are returned on a single response port tagged with the requester ID. It sits between the ALU-side requesters and replaces per-requester combinational division units.

## Interface
- WIDTH, 4: operand, quotient and remainder width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  WIDTH  requester 0 dividend
- req0_b  in  WIDTH  requester 0 divisor
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- rsp_q  out  WIDTH  quotient, floor(a/b)
- rsp_r  out  WIDTH  remainder, a mod b
- rsp_dbz  out  1  divisor was zero

## Operation
- States: IDLE, DIV, DONE. Reset enters IDLE.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dbz=0
  - req0_ready=0, req1_ready=0
  - priority pointer=0 (requester 0 favoured)
  - iteration counter=0
- Arbitration, IDLE only:
  - If exactly one valid is asserted, that requester is granted.
  - If both are asserted, the pointer's requester is granted.
  - reqN_ready = (state==IDLE) && granted==N. It is combinational from valids and state.
  - At most one ready is high per cycle.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready at a rising edge.
  - A requester holds valid and operands stable until the transfer.
  - A requester may deassert valid before being granted. Nothing is recorded in that case.
- On accept:
  - Latch a into the quotient shift register, b into the divisor register, and the ID.
  - Clear the remainder.
  - If b==0: go to DONE with rsp_dbz=1, rsp_q=all ones, rsp_r=a.
  - Otherwise: go to DIV with counter=0.
- DIV, one step per cycle, WIDTH steps:
  - Form WIDTH+1-bit t = {r, q_msb}.
  - Shift q left by one.
  - If t ≥ {0,b}: r = t−b and q lsb = 1. Otherwise r = t[WIDTH-1:0] and q lsb = 0.
  - After step WIDTH−1, go to DONE.
- DONE:
  - rsp_valid=1. rsp_id, rsp_q, rsp_r and rsp_dbz are held stable.
  - On rsp_ready, go to IDLE, clear rsp_valid, and set pointer = ~rsp_id. This gives round-robin behaviour.
  - If rsp_ready is low, DONE holds indefinitely and no new request is accepted.
- All arithmetic is unsigned. No overflow is possible: q ≤ a and r < b.
- Reset mid-operation aborts immediately. The in-flight result is discarded and no response is issued.

## Timing
- Accept at edge E0. For b≠0, rsp_valid rises after edge E0+WIDTH. Latency is WIDTH+1 cycles from the accept cycle to the first cycle of rsp_valid.
- For b==0, rsp_valid rises after E0, with a latency of 1 cycle.
- The earliest next accept is the cycle after the rsp_valid && rsp_ready edge. The outputs in IDLE are not registered off a pending request, so there is one idle cycle between operations.
- Throughput with rsp_ready tied high: one operation per WIDTH+2 cycles.
- The response port is registered. Request readys are combinational.
- Asynchronous reset clears all state without waiting for clk. Outputs reach their reset values while rst_n is low.

## Test plan
- Single ops from requester 0, WIDTH=4, rsp_ready=1:
  - 13/10 gives q=0001, r=0011.
  - 8/2 gives q=0100, r=0000.
  - 9/3 gives q=0011, r=0000.
  - 15/3 gives q=0101, r=0000.
  - Each: rsp_id=0, rsp_dbz=0, rsp_valid exactly 5 cycles after the accept cycle.
- Divide by zero: req1 with a=0110, b=0000 gives, 1 cycle after accept, rsp_id=1, rsp_dbz=1, q=1111, r=0110.
- Contention:
  - Both valid continuously from reset. Accepts alternate 0,1,0,1, and rsp_id alternates to match.
  - Never both readys high in the same cycle.
- Backpressure:
  - Hold rsp_ready=0 for 7 cycles in DONE. The response stays stable and both readys stay 0.
  - The response completes on the first rsp_ready=1 edge.
- Reset mid-DIV:
  - Assert rst_n=0 two cycles after accepting 15/3. All outputs go to reset values immediately.
  - After release, no stale response appears, and the next request 8/2 gives q=0100, r=0000.
- Random self-check: 1000 random a and b with random valids and random rsp_ready, compared against a/b and a%b with the correct rsp_id.
